div_unit: RTL

- Multi-cycle iterative 32-bit integer divider for the EX stage of the 5-stage MIPS pipeline. Implements DIV and DIVU.
- It is the initiator side of the pipeline stall protocol: while a divide is in flight it asserts a stall request. The stall controller turns that request into the stall[5:0] vector, which holds PC/IF/ID/ID-EX and bubbles EX-MEM.
- When the divide finishes, it returns {remainder, quotient} for writing to HI/LO.

---
 rtl/div_unit.sv | 98 +++++++++
 1 files changed

// File: rtl/div_unit.sv
// div_unit: multi-cycle restoring divider (DIV/DIVU) for the EX stage.
// Returns {remainder, quotient} and requests a pipeline stall while busy.
module div_unit #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               signed_div_i,
    input  logic [WIDTH-1:0]   opdata1_i,
    input  logic [WIDTH-1:0]   opdata2_i,
    input  logic               start_i,
    input  logic               annul_i,
    output logic [2*WIDTH-1:0] result_o,
    output logic               ready_o,
    output logic               stallreq_o
);
    localparam int CW = $clog2(WIDTH) + 1;
    typedef enum logic [1:0] {FREE, BYZERO, ON, END} state_t;
    state_t           state_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] rem_q, dvd_q, dvs_q, rem_d, dvd_d;
    logic             qneg_q, rneg_q;
    logic [WIDTH:0]   shift_w, trial_w;
    logic             neg1_w, neg2_w;
    assign stallreq_o = start_i & ~ready_o;
    assign neg1_w     = signed_div_i & opdata1_i[WIDTH-1];
    assign neg2_w     = signed_div_i & opdata2_i[WIDTH-1];
    // dvd_q shifts quotient bits in from the right as dividend bits leave on the left
    always_comb begin
        shift_w = {rem_q, dvd_q[WIDTH-1]};
        trial_w = shift_w - {1'b0, dvs_q};
        rem_d   = trial_w[WIDTH] ? shift_w[WIDTH-1:0] : trial_w[WIDTH-1:0];
        dvd_d   = {dvd_q[WIDTH-2:0], ~trial_w[WIDTH]};
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= FREE;
            cnt_q    <= '0;
            rem_q    <= '0;
            dvd_q    <= '0;
            dvs_q    <= '0;
            qneg_q   <= 1'b0;
            rneg_q   <= 1'b0;
            result_o <= '0;
            ready_o  <= 1'b0;
        end else begin
            case (state_q)
                FREE: begin
                    ready_o  <= 1'b0;
                    result_o <= '0;
                    if (start_i && !annul_i) begin
                        if (opdata2_i == '0) begin
                            state_q <= BYZERO;
                        end else begin
                            state_q <= ON;
                            dvd_q   <= neg1_w ? -opdata1_i : opdata1_i;
                            dvs_q   <= neg2_w ? -opdata2_i : opdata2_i;
                            rem_q   <= '0;
                            cnt_q   <= '0;
                            qneg_q  <= neg1_w ^ neg2_w;
                            rneg_q  <= neg1_w;
                        end
                    end
                end
                BYZERO: begin
                    state_q  <= annul_i ? FREE : END;
                    result_o <= '0;
                    ready_o  <= ~annul_i;
                end
                ON: begin
                    if (annul_i) begin
                        state_q  <= FREE;
                        cnt_q    <= '0;
                        result_o <= '0;
                        ready_o  <= 1'b0;
                    end else begin
                        rem_q <= rem_d;
                        dvd_q <= dvd_d;
                        cnt_q <= cnt_q + 1'b1;
                        if (cnt_q == CW'(WIDTH - 1)) begin
                            result_o <= {rneg_q ? -rem_d : rem_d, qneg_q ? -dvd_d : dvd_d};
                            ready_o  <= 1'b1;
                            state_q  <= END;
                        end
                    end
                end
                END: begin
                    if (!start_i || annul_i) begin
                        state_q  <= FREE;
                        result_o <= '0;
                        ready_o  <= 1'b0;
                    end
                end
                default: state_q <= FREE;
            endcase
        end
    end
endmodule
